decod_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with enable, selectable output polarity and an auto-scan mode. In scan mode an internal prescaler and index counter step the active output through all 2^N lines. It generalises the fixed 3-to-8 combinational decoder. It drives multiplexed display digits and row strobes in the board designs, and can still act as a plain decoder when fed an external select.

---
 rtl/decod_scan.sv | 66 ++++++
 tb/tb_decod_scan.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decod_scan.sv
// decod_scan: registered N-to-2^N one-hot decoder with enable, output polarity select
// and an auto-scan mode driven by an internal prescaler and index counter.
module decod_scan #(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        sel,
    output logic [(1<<N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                wrap
);
    localparam int W  = 1 << N;
    localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [W-1:0]  OFF  = {W{ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t         state, nxt;
    logic [PW-1:0]  pre, pre_d;
    logic [N-1:0]   idx_d;
    logic           wrap_d;
    logic [W-1:0]   y_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb nxt = !en ? IDLE : (mode ? SCAN : DIRECT);

    // Next register values are decided from the incoming state so every output lands one edge after its cause.
    always_comb begin
        idx_d  = idx;
        pre_d  = '0;
        wrap_d = 1'b0;
        if (nxt == DIRECT)
            idx_d = sel;
        else if (nxt == SCAN && state != SCAN)
            idx_d = '0;
        else if (nxt == SCAN && pre == LAST) begin
            idx_d  = idx + 1'b1;
            wrap_d = &idx;
        end
        else if (nxt == SCAN)
            pre_d = pre + 1'b1;
        y_d = (nxt == IDLE) ? OFF : OFF ^ (W'(1) << idx_d);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx  <= '0;
            pre  <= '0;
            wrap <= 1'b0;
            y    <= OFF;
        end else begin
            idx  <= idx_d;
            pre  <= pre_d;
            wrap <= wrap_d;
            y    <= y_d;
        end
endmodule

// File: tb/tb_decod_scan.sv
// tb_decod_scan: three decoder configurations run in lockstep against a cycle-count
// reference model (scan index derived from time since scan entry).
module tb_decod_scan;
    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, mode = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] y0, y1;
    logic [3:0] y2;
    logic [2:0] idx0, idx1;
    logic [1:0] idx2;
    logic wrap0, wrap1, wrap2;
    logic [30:0] got;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    decod_scan #(.N(3), .DIV(4), .ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .y(y0), .idx(idx0), .wrap(wrap0));
    decod_scan #(.N(3), .DIV(4), .ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .y(y1), .idx(idx1), .wrap(wrap1));
    decod_scan #(.N(2), .DIV(1), .ACTIVE_LOW(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]), .y(y2), .idx(idx2), .wrap(wrap2));

    assign got = {y0, idx0, wrap0, y1, idx1, wrap1, y2, idx2, wrap2};

    // Reference: in scan, index = (edges since entry / DIV) mod lines; wrap on each full period.
    int m_t[3] = '{0, 0, 0};
    int m_idx[3] = '{0, 0, 0};
    bit m_scan[3] = '{0, 0, 0};
    bit m_on[3] = '{0, 0, 0};
    bit m_wrap[3] = '{0, 0, 0};

    always @(posedge clk or negedge rst_n)
        for (int i = 0; i < 3; i++) begin
            int mm, dv;
            mm = (i == 2) ? 4 : 8;
            dv = (i == 2) ? 1 : 4;
            if (!rst_n) begin
                m_t[i] = 0; m_idx[i] = 0; m_scan[i] = 0; m_on[i] = 0; m_wrap[i] = 0;
            end else if (!en) begin
                m_on[i] = 0; m_wrap[i] = 0; m_scan[i] = 0;
            end else if (!mode) begin
                m_on[i] = 1; m_idx[i] = int'(sel) % mm; m_wrap[i] = 0; m_scan[i] = 0;
            end else begin
                m_t[i] = m_scan[i] ? m_t[i] + 1 : 0;
                m_scan[i] = 1;
                m_on[i] = 1;
                m_idx[i] = (m_t[i] / dv) % mm;
                m_wrap[i] = (m_t[i] != 0) && (m_t[i] % (dv * mm) == 0);
            end
        end

    function automatic logic [30:0] exp_all();
        logic [7:0] a, c;
        logic [3:0] b;
        a = m_on[0] ? 8'(1 << m_idx[0]) : 8'h00;
        c = m_on[1] ? 8'(1 << m_idx[1]) : 8'h00;
        b = m_on[2] ? 4'(1 << m_idx[2]) : 4'h0;
        return {a, 3'(m_idx[0]), m_wrap[0], ~c, 3'(m_idx[1]), m_wrap[1], b, 2'(m_idx[2]), m_wrap[2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        en = 1'b1; mode = 1'b1; sel = 3'd5;
        repeat (3) tick();
        vectors++;
        if (got !== {8'h00, 3'd0, 1'b0, 8'hFF, 3'd0, 1'b0, 4'h0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset got=%h exp=%h", got, {8'h00, 3'd0, 1'b0, 8'hFF, 3'd0, 1'b0, 4'h0, 2'd0, 1'b0});
        end
        en = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_direct();
        logic [7:0] e;
        en = 1'b1; mode = 1'b0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            e = 8'h01 << s;
            for (int c = 0; c < 5; c++) begin
                tick();
                vectors++;
                if (y0 !== e || y1 !== ~e || idx0 !== 3'(s)) begin
                    miscompares++;
                    $display("FAIL direct sel=%0d y0=%h y1=%h idx=%0d exp y0=%h y1=%h", s, y0, y1, idx0, e, ~e);
                end
                vectors++;
                if (got !== exp_all()) begin
                    miscompares++;
                    $display("FAIL direct_model got=%h exp=%h", got, exp_all());
                end
            end
        end
    endtask

    task automatic test_scan();
        en = 1'b0; tick();
        en = 1'b1; mode = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick();
            vectors++;
            if (got !== exp_all()) begin
                miscompares++;
                $display("FAIL scan_model c=%0d got=%h exp=%h", c, got, exp_all());
            end
            vectors++;
            if (wrap0 !== (c == 32 || c == 64 || c == 96) || !$onehot(y0) || idx0 !== 3'((c / 4) % 8)) begin
                miscompares++;
                $display("FAIL scan_timing c=%0d wrap=%b y=%h idx=%0d exp_idx=%0d", c, wrap0, y0, idx0, (c / 4) % 8);
            end
        end
    endtask

    task automatic test_enable_gate();
        int n;
        en = 1'b0; tick();
        en = 1'b1; mode = 1'b1;
        n = 0;
        do begin tick(); n++; end while (idx0 != 3'd5 && n < 60);
        vectors++;
        if (idx0 !== 3'd5) begin
            miscompares++;
            $display("FAIL gate_reach idx=%0d exp=5", idx0);
        end
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (y0 !== 8'h00 || idx0 !== 3'd5 || y1 !== 8'hFF || got !== exp_all()) begin
                miscompares++;
                $display("FAIL gate_idle y0=%h y1=%h idx=%0d exp y0=00 y1=ff idx=5", y0, y1, idx0);
            end
        end
        en = 1'b1; tick();
        vectors++;
        if (y0 !== 8'h01 || idx0 !== 3'd0 || got !== exp_all()) begin
            miscompares++;
            $display("FAIL gate_restart y0=%h idx=%0d exp y0=01 idx=0", y0, idx0);
        end
    endtask

    task automatic test_mode_switch();
        int n;
        en = 1'b0; tick();
        en = 1'b1; mode = 1'b1;
        n = 0;
        do begin tick(); n++; end while (idx0 != 3'd3 && n < 60);
        mode = 1'b0; sel = 3'd6; tick();
        vectors++;
        if (y0 !== 8'h40 || idx0 !== 3'd6 || got !== exp_all()) begin
            miscompares++;
            $display("FAIL mode_direct y0=%h idx=%0d exp y0=40 idx=6", y0, idx0);
        end
        mode = 1'b1; tick();
        vectors++;
        if (y0 !== 8'h01 || idx0 !== 3'd0) begin
            miscompares++;
            $display("FAIL mode_rescan y0=%h idx=%0d exp y0=01 idx=0", y0, idx0);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            vectors++;
            if (idx0 !== ((c == 4) ? 3'd1 : 3'd0) || got !== exp_all()) begin
                miscompares++;
                $display("FAIL mode_prescale c=%0d idx=%0d exp=%0d", c, idx0, (c == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b0; tick();
        en = 1'b1; mode = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            vectors++;
            if (idx2 !== 2'(c % 4) || wrap2 !== (c == 4 || c == 8) || got !== exp_all()) begin
                miscompares++;
                $display("FAIL div1 c=%0d idx=%0d wrap=%b exp idx=%0d", c, idx2, wrap2, c % 4);
            end
        end
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (y2 !== 4'h0 || idx2 !== 2'd0 || y0 !== 8'h00 || y1 !== 8'hFF || wrap0 !== 1'b0 || idx0 !== 3'd0) begin
            miscompares++;
            $display("FAIL async_reset y2=%h idx2=%0d y0=%h y1=%h idx0=%0d exp 0,0,00,ff,0", y2, idx2, y0, y1, idx0);
        end
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++;
            if (got !== exp_all()) begin
                miscompares++;
                $display("FAIL after_reset c=%0d got=%h exp=%h", c, got, exp_all());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel = 3'($urandom);
            tick();
            vectors++;
            if (got !== exp_all()) begin
                miscompares++;
                $display("FAIL random c=%0d en=%b mode=%b sel=%0d got=%h exp=%h", c, en, mode, sel, got, exp_all());
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_enable_gate();
        test_mode_switch();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
